// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer.
//   trap_state_e           : sequencer FSM states
//   ADDR_*                 : machine-mode CSR addresses touched by the sequencer
//   MSTATUS_*              : mstatus bit positions (MIE, MPIE, MPP)
//   PRIV_*                 : privilege level encodings
//   trap_entry_status()    : mstatus image written on trap entry
//   trap_return_status()   : mstatus image written on MRET
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_TVAL   = 3'd3,
    W_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIRECT = 3'd6
  } trap_state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Trap entry: stash MIE into MPIE, disable interrupts, record prior privilege.
  function automatic logic [63:0] trap_entry_status(input logic [63:0] mstatus,
                                                    input logic [1:0]  priv);
    logic [63:0] m;
    m = mstatus;
    m[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    m[MSTATUS_MIE]  = 1'b0;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv;
    return m;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, drop MPP to user.
  function automatic logic [63:0] trap_return_status(input logic [63:0] mstatus);
    logic [63:0] m;
    m = mstatus;
    m[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    m[MSTATUS_MPIE] = 1'b1;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    return m;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Writeback/CSR/pipeline-control bundle between the core and the trap sequencer.
//   WB_*      : writeback-stage instruction info (core -> sequencer)
//   PRIVILEGE : current privilege level
//   CSR_*     : live mstatus / mtvec / mepc read values
//   TS_*      : CSR write port, pipeline stall/flush/redirect, privilege load, busy
// Modports: master = core side, slave = trap sequencer.
interface trap_sequencer_if;
  logic        WB_V;
  logic        WB_CS;
  logic        WB_MRET;
  logic [63:0] WB_CAUSE;
  logic [63:0] WB_PC;
  logic [63:0] WB_TVAL;
  logic [1:0]  PRIVILEGE;
  logic [63:0] CSR_MSTATUS;
  logic [63:0] CSR_MTVEC;
  logic [63:0] CSR_MEPC;

  logic        TS_CSR_WE;
  logic [11:0] TS_CSR_ADDR;
  logic [63:0] TS_CSR_WDATA;
  logic        TS_STALL;
  logic        TS_FLUSH;
  logic        TS_REDIRECT;
  logic [63:0] TS_TARGET;
  logic [1:0]  TS_PRIV;
  logic        TS_PRIV_WE;
  logic        TS_BUSY;

  modport master (
    output WB_V, WB_CS, WB_MRET, WB_CAUSE, WB_PC, WB_TVAL, PRIVILEGE,
           CSR_MSTATUS, CSR_MTVEC, CSR_MEPC,
    input  TS_CSR_WE, TS_CSR_ADDR, TS_CSR_WDATA, TS_STALL, TS_FLUSH,
           TS_REDIRECT, TS_TARGET, TS_PRIV, TS_PRIV_WE, TS_BUSY
  );

  modport slave (
    input  WB_V, WB_CS, WB_MRET, WB_CAUSE, WB_PC, WB_TVAL, PRIVILEGE,
           CSR_MSTATUS, CSR_MTVEC, CSR_MEPC,
    output TS_CSR_WE, TS_CSR_ADDR, TS_CSR_WDATA, TS_STALL, TS_FLUSH,
           TS_REDIRECT, TS_TARGET, TS_PRIV, TS_PRIV_WE, TS_BUSY
  );
endinterface

// File: rtl/trap_target_calc.sv
// Trap vector computation (combinational).
//   mtvec      in  64 : latched mtvec (bits 1:0 are the mode)
//   cause_irq  in  1  : cause is an interrupt (cause bit 63)
//   cause_code in  6  : low cause bits used as the vector index
//   target     out 64 : trap handler PC
module trap_target_calc (
  input  logic [63:0] mtvec,
  input  logic        cause_irq,
  input  logic [5:0]  cause_code,
  output logic [63:0] target
);

  logic [63:0] base_s;
  logic [63:0] offset_s;

  // Vectored mode offsets only interrupts; exceptions always land on the base.
  always_comb begin
    base_s   = {mtvec[63:2], 2'b00};
    offset_s = {56'd0, cause_code, 2'b00};
    if ((mtvec[1:0] == 2'b01) && cause_irq) begin
      target = base_s + offset_s;
    end else begin
      target = base_s;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap / MRET sequencer: on a trap it writes mepc, mcause, (mtval,) mstatus one
// per cycle and then redirects the pipeline to the trap vector in M-mode; on
// MRET it rewrites mstatus and redirects to mepc at the saved privilege.
//   CLK   in : rising-edge clock
//   RESET in : synchronous active-high reset (aborts any sequence)
//   bus      : trap_sequencer_if.slave (writeback inputs, CSR port, pipeline control)
// Build option: define TRAP_MTVAL_EN to include the mtval (0x343) write state.
module trap_sequencer
  import trap_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  trap_sequencer_if.slave  bus
);

  trap_state_e state_r;
  trap_state_e next_state_s;

  logic [63:0] cause_r;
  logic [61:0] pc_r;
`ifdef TRAP_MTVAL_EN
  logic [63:0] tval_r;
`endif
  logic [1:0]  priv_r;
  logic [63:0] mstatus_r;
  logic [63:0] mtvec_r;
  logic [61:0] mepc_r;
  logic        is_mret_r;

  logic        idle_s;
  logic        trap_accept_s;
  logic        mret_accept_s;
  logic [63:0] trap_target_s;

  logic        csr_we_s;
  logic [11:0] csr_addr_s;
  logic [63:0] csr_wdata_s;
  logic        redirect_s;
  logic [63:0] target_s;
  logic [1:0]  priv_s;

  // A simultaneous trap and MRET resolves to the trap.
  assign idle_s        = (state_r == IDLE);
  assign trap_accept_s = idle_s & bus.WB_V & bus.WB_CS;
  assign mret_accept_s = idle_s & bus.WB_V & bus.WB_MRET & ~bus.WB_CS;

  trap_target_calc u_target_calc (
    .mtvec      (mtvec_r),
    .cause_irq  (cause_r[63]),
    .cause_code (cause_r[5:0]),
    .target     (trap_target_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Snapshot of the request context, taken only on acceptance from IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cause_r   <= 64'd0;
      pc_r      <= 62'd0;
`ifdef TRAP_MTVAL_EN
      tval_r    <= 64'd0;
`endif
      priv_r    <= 2'b00;
      mstatus_r <= 64'd0;
      mtvec_r   <= 64'd0;
      mepc_r    <= 62'd0;
      is_mret_r <= 1'b0;
    end else if (trap_accept_s) begin
      cause_r   <= bus.WB_CAUSE;
      pc_r      <= bus.WB_PC[63:2];
`ifdef TRAP_MTVAL_EN
      tval_r    <= bus.WB_TVAL;
`endif
      priv_r    <= bus.PRIVILEGE;
      mstatus_r <= bus.CSR_MSTATUS;
      mtvec_r   <= bus.CSR_MTVEC;
      is_mret_r <= 1'b0;
    end else if (mret_accept_s) begin
      mstatus_r <= bus.CSR_MSTATUS;
      mepc_r    <= bus.CSR_MEPC[63:2];
      is_mret_r <= 1'b1;
    end
  end

  // Next-state and state-decoded outputs; only IDLE looks at the inputs.
  always_comb begin
    next_state_s = state_r;
    csr_we_s     = 1'b0;
    csr_addr_s   = 12'h000;
    csr_wdata_s  = 64'd0;
    redirect_s   = 1'b0;
    target_s     = 64'd0;
    priv_s       = 2'b00;
    case (state_r)
      IDLE: begin
        if (trap_accept_s) begin
          next_state_s = W_EPC;
        end else if (mret_accept_s) begin
          next_state_s = M_STATUS;
        end else begin
          next_state_s = IDLE;
        end
      end
      W_EPC: begin
        csr_we_s     = 1'b1;
        csr_addr_s   = ADDR_MEPC;
        csr_wdata_s  = {pc_r, 2'b00};
        next_state_s = W_CAUSE;
      end
      W_CAUSE: begin
        csr_we_s     = 1'b1;
        csr_addr_s   = ADDR_MCAUSE;
        csr_wdata_s  = cause_r;
`ifdef TRAP_MTVAL_EN
        next_state_s = W_TVAL;
`else
        next_state_s = W_STATUS;
`endif
      end
      W_TVAL: begin
`ifdef TRAP_MTVAL_EN
        csr_we_s     = 1'b1;
        csr_addr_s   = ADDR_MTVAL;
        csr_wdata_s  = tval_r;
        next_state_s = W_STATUS;
`else
        // Unreachable without mtval support; recover quietly.
        next_state_s = IDLE;
`endif
      end
      W_STATUS: begin
        csr_we_s     = 1'b1;
        csr_addr_s   = ADDR_MSTATUS;
        csr_wdata_s  = trap_entry_status(mstatus_r, priv_r);
        next_state_s = REDIRECT;
      end
      M_STATUS: begin
        csr_we_s     = 1'b1;
        csr_addr_s   = ADDR_MSTATUS;
        csr_wdata_s  = trap_return_status(mstatus_r);
        next_state_s = REDIRECT;
      end
      REDIRECT: begin
        redirect_s = 1'b1;
        if (is_mret_r) begin
          target_s = {mepc_r, 2'b00};
          priv_s   = mstatus_r[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end else begin
          target_s = trap_target_s;
          priv_s   = PRIV_M;
        end
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign bus.TS_CSR_WE    = csr_we_s;
  assign bus.TS_CSR_ADDR  = csr_addr_s;
  assign bus.TS_CSR_WDATA = csr_wdata_s;
  assign bus.TS_REDIRECT  = redirect_s;
  assign bus.TS_FLUSH     = redirect_s;
  assign bus.TS_PRIV_WE   = redirect_s;
  assign bus.TS_PRIV      = priv_s;
  assign bus.TS_TARGET    = target_s;
  assign bus.TS_BUSY      = ~idle_s;
  // Stall must assert in the very cycle a request shows up, before it is latched.
  assign bus.TS_STALL     = ~idle_s | (idle_s & bus.WB_V & (bus.WB_CS | bus.WB_MRET));

endmodule
